// File: rtl/ram_arb2.sv
// ram_arb2: round-robin arbiter and sequencer letting two requesters share one
// single-port RAM, with read data steered back to the issuing requester.
module ram_arb2 #(
   parameter int DATA_W = 72,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_wr,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_wr,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              ram_enb,
   output logic              ram_wr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   input  logic [DATA_W-1:0] ram_r_data
);

   logic              prio;
   logic              grant0;
   logic              grant1;
   logic              accept;
   logic              win_id;
   logic              win_wr;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;
   logic              vld_p1;
   logic              id_p1;
   logic              vld_p2;
   logic              id_p2;

   // Pointer only matters when both requesters contend.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (req0_valid && req1_valid) begin
         grant0 = ~prio;
         grant1 = prio;
      end else begin
         grant0 = req0_valid;
         grant1 = req1_valid;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign accept     = grant0 | grant1;
   assign win_id     = grant1;

   always_comb begin
      win_wr   = req0_wr;
      win_addr = req0_addr;
      win_data = req0_wdata;
      if (grant1) begin
         win_wr   = req1_wr;
         win_addr = req1_addr;
         win_data = req1_wdata;
      end
   end

   // Stage p1: command on the RAM pins; pins other than enb hold when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio     <= 1'b0;
         ram_enb  <= 1'b0;
         ram_wr   <= 1'b0;
         ram_addr <= '0;
         ram_data <= '0;
      end else begin
         ram_enb <= accept;
         if (accept) begin
            ram_wr   <= win_wr;
            ram_addr <= win_addr;
            ram_data <= win_data;
            prio     <= ~win_id;
         end
      end
   end

   // Stage p1 -> p2: read tag follows the RAM's one-cycle read latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         id_p1  <= 1'b0;
         vld_p2 <= 1'b0;
         id_p2  <= 1'b0;
      end else begin
         vld_p1 <= accept & ~win_wr;
         id_p1  <= win_id;
         vld_p2 <= vld_p1;
         id_p2  <= id_p1;
      end
   end

   assign rsp0_valid = vld_p2 & ~id_p2;
   assign rsp1_valid = vld_p2 & id_p2;
   assign rsp0_rdata = ram_r_data;
   assign rsp1_rdata = ram_r_data;

endmodule

// File: tb/tb_ram_arb2.sv
// Bench for ram_arb2: behavioural RAM plus a transaction-level reference model
// (pointer, memory image and an expected-response queue).
module tb_ram_arb2;
   localparam int DATA_W = 72;
   localparam int ADDR_W = 2;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              req0_valid, req0_ready, req0_wr;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_wdata;
   logic              req1_valid, req1_ready, req1_wr;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_wdata;
   logic              rsp0_valid, rsp1_valid;
   logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
   logic              ram_enb, ram_wr;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_data;
   logic [DATA_W-1:0] ram_r_data;

   ram_arb2 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .ram_enb(ram_enb), .ram_wr(ram_wr), .ram_addr(ram_addr),
      .ram_data(ram_data), .ram_r_data(ram_r_data)
   );

   always #5 clk = ~clk;

   // Single-port RAM with registered read data.
   logic [DATA_W-1:0] ram_mem [DEPTH];
   always @(posedge clk) begin
      if (ram_enb) begin
         if (ram_wr) ram_mem[ram_addr] <= ram_data;
         else        ram_r_data <= ram_mem[ram_addr];
      end
   end

   typedef struct {
      int                due;
      bit                id;
      logic [DATA_W-1:0] data;
   } rsp_t;

   int                errors = 0;
   int                checks = 0;
   int                cyc    = 0;
   bit                m_prio;
   logic [DATA_W-1:0] m_mem [DEPTH];
   bit                e_enb, e_wr;
   logic [ADDR_W-1:0] e_addr;
   logic [DATA_W-1:0] e_data;
   rsp_t              rq[$];

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                      input logic [DATA_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      rsp_t r;
      chk("ram_enb", ram_enb, e_enb);
      chk("ram_wr", ram_wr, e_wr);
      chk("ram_addr", ram_addr, e_addr);
      if (e_enb && e_wr) chk("ram_data", ram_data, e_data);
      if (rq.size() > 0 && rq[0].due == cyc) begin
         r = rq.pop_front();
         chk("rsp0_valid", rsp0_valid, !r.id);
         chk("rsp1_valid", rsp1_valid, r.id);
         if (r.id) chk("rsp1_rdata", rsp1_rdata, r.data);
         else      chk("rsp0_rdata", rsp0_rdata, r.data);
      end else begin
         chk("rsp0_valid", rsp0_valid, 1'b0);
         chk("rsp1_valid", rsp1_valid, 1'b0);
      end
   endtask

   // One clock: present inputs, check readies against the model, advance.
   task automatic step(input bit v0, input bit w0, input logic [ADDR_W-1:0] a0,
                       input logic [DATA_W-1:0] d0,
                       input bit v1, input bit w1, input logic [ADDR_W-1:0] a1,
                       input logic [DATA_W-1:0] d1, output int g);
      bit                g0, g1, w;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      req0_valid = v0; req0_wr = w0; req0_addr = a0; req0_wdata = d0;
      req1_valid = v1; req1_wr = w1; req1_addr = a1; req1_wdata = d1;
      #1;
      g0 = v0 && (!v1 || !m_prio);
      g1 = v1 && (!v0 || m_prio);
      chk("req0_ready", req0_ready, g0);
      chk("req1_ready", req1_ready, g1);
      g = req0_ready ? 0 : (req1_ready ? 1 : -1);
      @(posedge clk);
      cyc++;
      if (g0 || g1) begin
         w = g0 ? w0 : w1;
         a = g0 ? a0 : a1;
         d = g0 ? d0 : d1;
         e_enb = 1'b1; e_wr = w; e_addr = a; e_data = d;
         if (w) m_mem[a] = d;
         else   rq.push_back('{due: cyc + 1, id: g1, data: m_mem[a]});
         m_prio = g0;
      end else begin
         e_enb = 1'b0;
      end
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst = 1'b1;
      m_prio = 1'b0;
      e_enb = 1'b0; e_wr = 1'b0; e_addr = '0; e_data = '0;
      rq.delete();
      #1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ram_enb", ram_enb, 1'b0);
      chk("rst_ram_wr", ram_wr, 1'b0);
      chk("rst_ram_addr", ram_addr, '0);
      chk("rst_ram_data", ram_data, '0);
      chk("rst_rsp0_valid", rsp0_valid, 1'b0);
      chk("rst_rsp1_valid", rsp1_valid, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      int                g;
      int                idx0, idx1;
      bit                p0, p1, w0, w1;
      logic [ADDR_W-1:0] a0, a1;
      logic [DATA_W-1:0] d0, d1;
      logic [95:0]       rnd;

      rst = 1'b0;
      req0_valid = 1'b0; req0_wr = 1'b0; req0_addr = '0; req0_wdata = '0;
      req1_valid = 1'b0; req1_wr = 1'b0; req1_addr = '0; req1_wdata = '0;
      @(negedge clk);

      // Reset then idle
      do_reset();
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 0, 0, g);

      // Single requester write then read-after-write
      step(1, 1, 2'd2, 72'hA5, 0, 0, 0, 0, g);
      chk("wr_grant", g, 0);
      step(1, 0, 2'd2, 0, 0, 0, 0, 0, g);
      chk("rd_grant", g, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, g);

      // Preload 1..4, last grant to requester 1 leaves the pointer at 0
      step(1, 1, 2'd0, 72'd1, 0, 0, 0, 0, g);
      step(0, 0, 0, 0, 1, 1, 2'd1, 72'd2, g);
      step(1, 1, 2'd2, 72'd3, 0, 0, 0, 0, g);
      step(0, 0, 0, 0, 1, 1, 2'd3, 72'd4, g);

      // Contention fairness: losers keep presenting their command
      idx0 = 0; idx1 = 0;
      for (int i = 0; i < 8; i++) begin
         step(1, 0, ADDR_W'(idx0 % DEPTH), 0, 1, 0, ADDR_W'((idx1 + 1) % DEPTH), 0, g);
         chk("rr_grant", g, i % 2);
         if (g == 0) idx0++;
         if (g == 1) idx1++;
      end
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, g);

      // Mixed write/read contention on the same address
      step(1, 1, 2'd1, 72'hFF, 1, 0, 2'd1, 0, g);
      chk("mix_grant0", g, 0);
      step(0, 0, 0, 0, 1, 0, 2'd1, 0, g);
      chk("mix_grant1", g, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, g);
      chk("mix_rsp1_rdata", rsp1_rdata, 72'hFF);
      for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0, 0, 0, g);

      // Reset mid-flight: read from req1 is dropped, pointer returns to 0
      step(0, 0, 0, 0, 1, 0, 2'd3, 0, g);
      chk("mid_grant", g, 1);
      do_reset();
      step(1, 0, 2'd0, 0, 1, 0, 2'd2, 0, g);
      chk("post_rst_grant", g, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, g);

      // Randomized traffic with held commands
      p0 = 0; p1 = 0; w0 = 0; w1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
      for (int i = 0; i < 400; i++) begin
         if (!p0 && $urandom_range(0, 3) != 0) begin
            p0 = 1; w0 = 1'($urandom_range(0, 1)); a0 = ADDR_W'($urandom_range(0, DEPTH - 1));
            rnd = {$urandom(), $urandom(), $urandom()}; d0 = rnd[DATA_W-1:0];
         end
         if (!p1 && $urandom_range(0, 3) != 0) begin
            p1 = 1; w1 = 1'($urandom_range(0, 1)); a1 = ADDR_W'($urandom_range(0, DEPTH - 1));
            rnd = {$urandom(), $urandom(), $urandom()}; d1 = rnd[DATA_W-1:0];
         end
         step(p0, w0, a0, d0, p1, w1, a1, d1, g);
         if (g == 0) p0 = 0;
         if (g == 1) p1 = 0;
      end
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, g);
      chk("rsp_queue_drained", 72'(rq.size()), 72'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_arb2.md
# ram_arb2

Two-port round-robin arbiter and sequencer in front of the single-port 4-entry × 72-bit RAM. Two independent requesters issue read/write commands over valid/ready handshakes. The block grants one command per cycle, drives the RAM enable/write/address/data pins from registers, and routes each read's data back to the requester that issued it. It sits between the two datapath clients and the RAM and is the only agent driving the RAM pins.

## Interface
Parameters:
- DATA_W, 72: RAM word width.
- ADDR_W, 2: RAM address width (depth 2**ADDR_W).

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req0_valid / req1_valid  input  1  requester N has a command.
- req0_ready / req1_ready  output  1  command of requester N is accepted this cycle.
- req0_wr / req1_wr  input  1  1 = write, 0 = read.
- req0_addr / req1_addr  input  ADDR_W  command address.
- req0_wdata / req1_wdata  input  DATA_W  write data; ignored for reads.
- rsp0_valid / rsp1_valid  output  1  one-cycle pulse: read data for requester N is on rspN_rdata.
- rsp0_rdata / rsp1_rdata  output  DATA_W  read data; only meaningful while rspN_valid=1.
- ram_enb  output  1  to RAM enb.
- ram_wr  output  1  to RAM wr.
- ram_addr  output  ADDR_W  to RAM addr.
- ram_data  output  DATA_W  to RAM data.
- ram_r_data  input  DATA_W  from RAM r_data; registered by the RAM, valid one cycle after the RAM samples a read.

## Operation
- Arbitration is combinational on the valid inputs and the registered priority pointer `prio` (0 or 1).
  - One valid only: that requester is granted.
  - Both valid: requester `prio` is granted.
  - reqN_ready = grantN. Ready depends on valid, and at most one ready is high per cycle.
- On a granted handshake (valid & ready high at an edge):
  - Register ram_enb=1, ram_wr, ram_addr and ram_data from the winner.
  - Set `prio` to the other requester.
  - Capture a read tag {is_read, requester id}.
- If no requester is granted, ram_enb is registered to 0 and `prio` is unchanged. ram_addr, ram_data and ram_wr hold their last values.
- Read tag pipeline:
  - Stage 1 aligns with the RAM command cycle.
  - Stage 2 aligns with the cycle in which ram_r_data is valid.
  - In stage 2: rspN_valid = stage2.is_read & (stage2.id == N).
  - rspN_rdata = ram_r_data for both requesters (shared bus); consumers qualify it with rspN_valid.
- Writes produce no response.
- Commands are never reordered. Back-to-back commands to the same address take effect in acceptance order.
- There is no response backpressure. Requesters must always accept rspN_valid.

## Timing
- Reset: ram_enb=0, ram_wr=0, ram_addr=0, ram_data=0, `prio`=0, both tag stages cleared. Therefore rsp0_valid=0 and rsp1_valid=0.
- reqN_ready is combinational during reset. Any handshake while rst=1 is discarded.
- Accept at edge E0:
  - Cycle after E0: RAM pins driven.
  - Edge E1: RAM samples the command (write committed, or read registered).
  - Cycle after E1: ram_r_data valid and rspN_valid=1.
  - Read latency from accepting edge to response cycle: 2 cycles.
- Throughput: one command per cycle, sustained with both requesters continuously valid, strictly alternating 0,1,0,1.
- Read-after-write: write accepted at E0 and read of the same address accepted at E0+1. The read returns the new data because the RAM write commits at E1, before the read samples at E1+1.
- Simultaneous events:
  - Both valid: the pointer decides.
  - A single valid requester is granted every cycle regardless of `prio`, and `prio` still flips to the other requester.
- Reset asserted mid-operation:
  - In-flight reads are dropped and no rsp pulse is produced.
  - Writes already on the RAM pins may or may not commit.
  - After release, arbitration restarts with `prio`=0.

## Test plan
- Reset then idle: rst pulse with both valids low. Required: ram_enb=0, rsp0_valid=rsp1_valid=0, req0_ready=req1_ready=0 for 10 cycles.
- Single requester write/read: req0 writes 72'hA5 to addr 2 at E0, then reads addr 2 at E0+1. Required: ram_enb=1/ram_wr=1/ram_addr=2 in the cycle after E0. rsp0_valid pulses exactly 2 cycles after the read's accept with rdata=72'hA5. rsp1_valid stays 0.
- Contention fairness: both requesters valid for 8 cycles, reading addresses 0..3 preloaded with 1,2,3,4. Required: grants alternate 0,1,0,1,… starting with requester 0. Each response goes only to the issuing requester with the correct data.
- Mixed read/write contention: req0 writes 72'hFF to addr 1 while req1 reads addr 1 in the same cycle, with `prio`=0. Required: req0 granted first, req1 granted next cycle. rsp1_rdata=72'hFF.
- Reset mid-flight: accept a read from req1, assert rst one cycle later. Required: no rsp1_valid pulse, `prio` returns to 0, and the first grant after release goes to requester 0.
